// File: rtl/multicycle_ctrl.sv
// Control unit for the multicycle ARM-subset datapath: main FSM, ALU decode,
// condition check and NZCV flag register. Optional macro: CMP_SUPPORT_EN.
module multicycle_ctrl #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  typedef struct packed {
    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
  } main_ctrl_t;

  state_t     state;
  state_t     state_next;
  main_ctrl_t ctrl;

  logic [1:0] flag_w;
  logic       no_write;
  logic       cond_ex;
  logic       cond_ex_q;
  logic       pcs;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: next-state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = S_FETCH;
    unique case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        unique case (Op)
          2'b01:   state_next = S_MEMADR;
          2'b00:   state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_next = S_BRANCH;
          default: state_next = S_FETCH;  // undefined instruction
        endcase
      end
      S_MEMADR:   state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWR:    state_next = S_FETCH;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-state control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.next_pc    = 1'b1;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
      end
      S_MEMADR: ctrl.alu_src_b = 2'b01;
      S_MEMRD:  ctrl.adr_src   = 1'b1;
      S_MEMWB: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_w   = 1'b1;
      end
      S_EXECUTER: ctrl.alu_op = 1'b1;
      S_EXECUTEI: begin
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = 1'b1;
      end
      S_ALUWB: ctrl.reg_w = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_b  = 2'b01;
        ctrl.result_src = 2'b10;
        ctrl.branch     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU decode
  // ---------------------------------------------------------------------------
  always_comb begin
    ALUControl = 2'b00;
    flag_w     = 2'b00;
    if (ctrl.alu_op) begin
      unique case (Funct[4:1])
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
`ifdef CMP_SUPPORT_EN
        4'b1010: ALUControl = 2'b01;
`else
        4'b1010: ALUControl = 2'b00;
`endif
        default: ALUControl = 2'b00;
      endcase
      // C and V only make sense for the arithmetic operations.
      flag_w = {Funct[0], Funct[0] & ~ALUControl[1]};
    end
  end

  // Compare discards its result; restricted to data-processing so a memory
  // op with the same Funct bits still writes back.
`ifdef CMP_SUPPORT_EN
  assign no_write = (Op == 2'b00) && (Funct[4:1] == 4'b1010);
`else
  assign no_write = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Condition check against the current flag register
  // ---------------------------------------------------------------------------
  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = Flags;

  always_comb begin
    cond_ex = 1'b0;
    unique case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Captured once per instruction so later flag updates cannot change it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cond_ex_q <= 1'b0;
    else if (state == S_DECODE) cond_ex_q <= cond_ex;
  end

  // ---------------------------------------------------------------------------
  // NZCV flag register (flag_w is nonzero only in the execute states)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= RESET_FLAGS;
    end else begin
      if (flag_w[1] && cond_ex_q) Flags[3:2] <= ALUFlags[3:2];
      if (flag_w[0] && cond_ex_q) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Write gating; enables are forced low while reset is held
  // ---------------------------------------------------------------------------
  assign pcs      = ctrl.branch | (ctrl.reg_w & (Rd == 4'd15));
  assign PCWrite  = ~reset & (ctrl.next_pc | (pcs & cond_ex_q));
  assign RegWrite = ~reset & ctrl.reg_w & cond_ex_q & ~no_write;
  assign MemWrite = ~reset & ctrl.mem_w & cond_ex_q;
  assign IRWrite  = ~reset & ctrl.ir_write;

  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign ImmSrc    = Op;
  assign RegSrc    = {Op == 2'b01, Op == 2'b10};

  // ---------------------------------------------------------------------------
  // Sanity properties
  // ---------------------------------------------------------------------------
  a_no_mem_and_reg_write: assert property (
    @(posedge clk) disable iff (reset) !(MemWrite && RegWrite));
  a_ir_write_only_fetch: assert property (
    @(posedge clk) disable iff (reset) IRWrite |-> (state == S_FETCH));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised self-checking bench for multicycle_ctrl: a state-list model of
// each instruction predicts every cycle's controls and the NZCV register.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0] Flags;

  multicycle_ctrl #(.RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .Flags(Flags)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] m_flags;
  logic       m_cx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] fl);
    logic n, z, cy, v;
    {n, z, cy, v} = fl;
    case (c)
      4'h0: return z;             4'h1: return !z;
      4'h2: return cy;            4'h3: return !cy;
      4'h4: return n;             4'h5: return !n;
      4'h6: return v;             4'h7: return !v;
      4'h8: return cy && !z;      4'h9: return !cy || z;
      4'hA: return n == v;        4'hB: return n != v;
      4'hC: return !z && n == v;  4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] dp_op(input logic [5:0] f);
    case (f[4:1])
      4'b0100: return 2'd0;
      4'b0010: return 2'd1;
      4'b0000: return 2'd2;
      4'b1100: return 2'd3;
`ifdef CMP_SUPPORT_EN
      4'b1010: return 2'd1;
`endif
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic is_cmp(input logic [5:0] f);
`ifdef CMP_SUPPORT_EN
    return f[4:1] == 4'b1010;
`else
    return 1'b0;
`endif
  endfunction

  // Expected {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,
  // ResultSrc,ImmSrc,RegSrc,ALUControl} for one named state.
  function automatic logic [15:0] exp_ctrl(input string st, input logic [1:0] o,
                                           input logic [5:0] f, input logic [3:0] r,
                                           input logic cx);
    logic pcw = 0, mw = 0, rw = 0, irw = 0, adr = 0, sa = 0;
    logic [1:0] sb = 0, res = 0, alu = 0;
    case (st)
      "FETCH":    begin irw = 1; pcw = 1; sa = 1; sb = 2; res = 2; end
      "DECODE":   begin sa = 1; sb = 2; res = 2; end
      "MEMADR":   sb = 1;
      "MEMRD":    adr = 1;
      "MEMWB":    begin res = 1; rw = cx; pcw = cx && r == 15; end
      "MEMWR":    begin adr = 1; mw = cx; end
      "EXECUTER": alu = dp_op(f);
      "EXECUTEI": begin sb = 1; alu = dp_op(f); end
      "ALUWB":    begin rw = cx && !is_cmp(f); pcw = cx && r == 15; end
      "BRANCH":   begin sb = 1; res = 2; pcw = cx; end
      default:    ;
    endcase
    return {pcw, mw, rw, irw, adr, sa, sb, res, o, o == 2'b01, o == 2'b10, alu};
  endfunction

  task automatic check_in_reset(input string tag);
    check({tag, "_ctrl"}, obs, exp_ctrl("FETCH", Op, Funct, Rd, 1'b0) & 16'h0FFF);
    check({tag, "_flags"}, Flags, 4'b0000);
  endtask

  // Runs one instruction starting in FETCH (called at posedge+1). af<0 means
  // random ALUFlags; abort_at>=0 asserts reset after that state is checked.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r,
                           input int af, input int abort_at);
    string seq[$];
    logic [1:0] alu;
    seq = '{"FETCH", "DECODE"};
    case (o)
      2'b01: begin
        seq.push_back("MEMADR");
        if (f[0]) begin seq.push_back("MEMRD"); seq.push_back("MEMWB"); end
        else seq.push_back("MEMWR");
      end
      2'b00: begin
        seq.push_back(f[5] ? "EXECUTEI" : "EXECUTER");
        seq.push_back("ALUWB");
      end
      2'b10: seq.push_back("BRANCH");
      default: ;
    endcase
    Cond = c; Op = o; Funct = f; Rd = r;
    foreach (seq[i]) begin
      ALUFlags = (af < 0) ? 4'($urandom) : 4'(af);
      @(negedge clk);
      check(seq[i], obs, exp_ctrl(seq[i], o, f, r, m_cx));
      check("flags", Flags, m_flags);
      if (i == abort_at) begin
        #1 reset = 1'b1;
        #1 check_in_reset("abort_reset");
        @(posedge clk);
        #1 check_in_reset("abort_hold");
        reset = 1'b0;
        m_flags = 4'b0000;
        m_cx = 1'b0;
        return;
      end
      if (seq[i] == "DECODE") m_cx = cond_holds(c, m_flags);
      if (seq[i] == "EXECUTER" || seq[i] == "EXECUTEI") begin
        alu = dp_op(f);
        if (m_cx && f[0]) begin
          m_flags[3:2] = ALUFlags[3:2];
          if (alu == 2'd0 || alu == 2'd1) m_flags[1:0] = ALUFlags[1:0];
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [3:0] codes [5];
    logic [3:0] rc, rr;
    logic [1:0] ro;
    logic [5:0] rf;
    codes = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    reset = 1'b1;
    Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    m_flags = 4'b0000;
    m_cx = 1'b0;
    #3 check_in_reset("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // ADDS R1,R2,R3 with ALUFlags=0100
    run_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0100, -1);
    check("adds_flags", Flags, 4'b0100);
    // clear Z, then SUBEQ must not write or change flags
    run_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0000, -1);
    run_instr(4'b0000, 2'b00, 6'b000101, 4'd2, 4'b1111, -1);
    check("subeq_flags", Flags, 4'b0000);
    // LDR, STR, B, undefined
    run_instr(4'b1110, 2'b01, 6'b011001, 4'd3, -1, -1);
    run_instr(4'b1110, 2'b01, 6'b011000, 4'd3, -1, -1);
    run_instr(4'b1110, 2'b10, 6'b100000, 4'd0, -1, -1);
    run_instr(4'b1110, 2'b11, 6'b000000, 4'd0, -1, -1);
    // CMP with ALUFlags=0110
    run_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0110, -1);
    check("cmp_flags", Flags, 4'b0110);
    // write to R15 via data-processing
    run_instr(4'b1110, 2'b00, 6'b101000, 4'd15, -1, -1);

    for (int k = 0; k < 300; k++) begin
      rc = 4'($urandom);
      ro = 2'($urandom);
      rf = 6'($urandom);
      rr = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      if (ro == 2'b00 && $urandom_range(0, 1) == 1) rf[4:1] = codes[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) rc = 4'hE;
      run_instr(rc, ro, rf, rr, -1, -1);
    end

    // reset while in MEMRD (state index 3), flags made nonzero first
    run_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b1111, -1);
    run_instr(4'b1110, 2'b01, 6'b011001, 4'd4, -1, 3);
    @(negedge clk);
    check("post_reset_irwrite", IRWrite, 1'b1);
    check("post_reset_pcwrite", PCWrite, 1'b1);
    check("post_reset_flags", Flags, 4'b0000);
    @(posedge clk);
    // state is now DECODE; finish the instruction boundary cleanly
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    run_instr(4'b1110, 2'b10, 6'b000000, 4'd0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
